// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multi-cycle sequencer FSM; define ILLEGAL_TRAP_EN to trap illegal opcodes
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               BranchCond,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         ALUControl,
  output logic [1:0]         ResultSrc,
  output logic [2:0]         ImmSrc,
  output logic [2:0]         BranchType,
  output logic [2:0]         AddressingControl,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_dbg
);
  typedef enum logic [STATE_W-1:0] {
    S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4, S_MEMWRITE = 5,
    S_EXECR = 6, S_EXECI = 7, S_EXECU = 8, S_ALUWB = 9, S_BRANCH = 10, S_JAL = 11,
    S_JALR = 12, S_TRAP = 13
  } state_t;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  state_t r_state, w_next;
  logic w_req, w_adr, w_irw, w_pcw, w_rw, w_mw, w_done;
  logic [1:0] w_srca, w_srcb, w_res;
  logic [3:0] w_alu;
  logic [2:0] w_imm, w_bt, w_ac, w_dec_imm;
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? 4'b0001 : 4'b0000;
      3'b001:  return 4'b0101;
      3'b010:  return 4'b1000;
      3'b011:  return 4'b1001;
      3'b100:  return 4'b0100;
      3'b101:  return alt ? 4'b0111 : 4'b0110;
      3'b110:  return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction
  assign w_dec_imm = (opcode == OP_STORE) ? 3'b001 :
                     (opcode == OP_BR) ? 3'b010 :
                     (opcode == OP_JAL) ? 3'b011 :
                     (opcode == OP_LUI || opcode == OP_AUIPC) ? 3'b100 : 3'b000;
  always_ff @(posedge clk)
    r_state <= rst ? S_FETCH : w_next;
  always_comb begin
    w_next = S_FETCH;
    w_req  = 1'b0;
    w_adr  = 1'b0;
    w_irw  = 1'b0;
    w_pcw  = 1'b0;
    w_rw   = 1'b0;
    w_mw   = 1'b0;
    w_srca = 2'b00;
    w_srcb = 2'b00;
    w_res  = 2'b00;
    w_alu  = 4'b0000;
    w_imm  = 3'b000;
    w_bt   = 3'b000;
    w_ac   = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_req  = 1'b1;
        w_irw  = mem_ready;
        w_pcw  = mem_ready;
        w_srcb = mem_ready ? 2'b10 : 2'b00;
        w_res  = mem_ready ? 2'b10 : 2'b00;
        w_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_srca = 2'b01;
        w_srcb = 2'b01;
        w_imm  = w_dec_imm;
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECR;
          OP_I:              w_next = S_EXECI;
          OP_LUI, OP_AUIPC:  w_next = S_EXECU;
          OP_BR:             w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
`ifdef ILLEGAL_TRAP_EN
          default:           w_next = S_TRAP;
`else
          default:           w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        w_srca = 2'b10;
        w_srcb = 2'b01;
        w_imm  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
        w_ac   = funct3;
        w_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_req  = 1'b1;
        w_adr  = 1'b1;
        w_ac   = funct3;
        w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_res  = 2'b01;
        w_rw   = 1'b1;
        w_ac   = funct3;
        w_next = S_FETCH;
      end
      S_MEMWRITE: begin
        w_req  = 1'b1;
        w_adr  = 1'b1;
        w_mw   = 1'b1;
        w_ac   = funct3;
        w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        w_srca = 2'b10;
        w_alu  = alu_dec(funct3, funct7 == 7'b0100000);
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        w_srca = 2'b10;
        w_srcb = 2'b01;
        w_alu  = alu_dec(funct3, funct3 == 3'b101 && funct7[5]);
        w_next = S_ALUWB;
      end
      S_EXECU: begin
        w_srca = (opcode == OP_LUI) ? 2'b00 : 2'b01;
        w_srcb = 2'b01;
        w_imm  = 3'b100;
        w_alu  = (opcode == OP_LUI) ? 4'b1111 : 4'b0000;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw   = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_srca = 2'b10;
        w_bt   = funct3;
        w_alu  = funct3[2] ? (funct3[1] ? 4'b1001 : 4'b1000) : 4'b0001;
        w_pcw  = BranchCond;
        w_next = S_FETCH;
      end
      S_JAL: begin
        w_srca = 2'b01;
        w_srcb = 2'b10;
        w_pcw  = 1'b1;
        w_next = S_ALUWB;
      end
      S_JALR: begin
        w_srca = 2'b10;
        w_srcb = 2'b01;
        w_next = S_JAL;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: w_next = S_TRAP;
`endif
      default: w_next = S_FETCH;
    endcase
  end
  assign w_done = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_TRAP);
  assign {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB, ALUControl,
          ResultSrc, ImmSrc, BranchType, AddressingControl, instr_done} = rst ? '0 :
         {w_req, w_adr, w_irw, w_pcw, w_rw, w_mw, w_srca, w_srcb, w_alu,
          w_res, w_imm, w_bt, w_ac, w_done};
  assign state_dbg = rst ? '0 : r_state;
endmodule
